rr_arbiter_mux: RTL and testbench
=================================

Name: rr_arbiter_mux

Overview:
Parametrised N-channel multiplexer with valid/ready handshake on every input and on the output. It selects one requesting channel per transfer, using fixed-priority, round-robin, or externally forced selection (MODE). The selected word is registered into a single-entry output stage. It sits wherever several producers share one datapath consumer, and replaces hard-wired 2:1 data selection with arbitrated, flow-controlled selection.

Parameters:
WORD_LENGHT, 8, data width in bits of each channel and of the output.
CHANNELS, 4, number of input channels; legal range 2..16.
MODE, 1, selection mode: 0 = fixed priority (lowest index wins), 1 = round robin, 2 = forced (Selector input).
SEL_W, $clog2(CHANNELS), width of Selector and Out_Channel; derived, not overridden.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
In_Valid  input  CHANNELS  bit i high = channel i presents a word.
In_Data  input  CHANNELS*WORD_LENGHT  flattened data; channel i occupies bits [i*WORD_LENGHT +: WORD_LENGHT].
In_Ready  output  CHANNELS  bit i high = channel i's word is taken this cycle; at most one bit high.
Selector  input  SEL_W  channel index used in MODE 2; ignored otherwise.
Out_Valid  output  1  output register holds a valid word.
Out_Data  output  WORD_LENGHT  registered selected word.
Out_Channel  output  SEL_W  index of the channel that supplied Out_Data.
Out_Ready  input  1  consumer accepts Out_Data this cycle when Out_Valid is high.

Behaviour:
- Reset (sampled on clk edge while reset=1): Out_Valid=0, Out_Data=0, Out_Channel=0, round-robin pointer=0, FSM=EMPTY. In_Ready is forced to 0 while reset is high. Reset mid-transfer discards the held word and does not complete any handshake.
- Output FSM: EMPTY (Out_Valid=0), FULL (Out_Valid=1).
- load_en = (state==EMPTY) | Out_Ready. A word is drained and a new one loaded in the same cycle, so throughput is 1 word/cycle.
- Grant, combinational from In_Valid:
  - MODE 0: lowest-index valid channel.
  - MODE 1: first valid channel at or after the pointer, searching upward modulo CHANNELS.
  - MODE 2: channel Selector if In_Valid[Selector]=1. If Selector >= CHANNELS, no grant.
- In_Ready[i] = load_en & grant[i] & ~reset. A transfer on channel i occurs when In_Valid[i] & In_Ready[i].
- On a transfer: Out_Data <= In_Data[i], Out_Channel <= i, state <= FULL. Latency is 1 clock from the input handshake to Out_Valid.
- If load_en is high with no grant: FULL & Out_Ready goes to EMPTY; EMPTY stays EMPTY.
- If FULL & ~Out_Ready: Out_Data and Out_Channel hold stable and all In_Ready are 0.
- Round-robin pointer (MODE 1 only): after a transfer from channel k, pointer <= (k+1) mod CHANNELS, wrapping from CHANNELS-1 to 0. The pointer is unchanged when there is no transfer.
- In MODE 0 and MODE 2 the pointer stays 0.
- A non-granted valid channel must hold its data and valid until it is served (standard valid/ready rule). The block never drops or duplicates a word.
- With no valid inputs, Out_Data keeps its last value while Out_Valid=0.

Test Plan:
- Reset: assert reset 2 cycles with all In_Valid=1 -> In_Ready=0, Out_Valid=0, Out_Data=0x00, Out_Channel=0. Deassert -> first transfer from channel 0 on the next edge.
- Round robin (MODE 1, CHANNELS=4): In_Valid=4'b1111 held, data 0xA0..0xA3, Out_Ready=1 -> Out_Channel sequence 0,1,2,3,0 on consecutive cycles with Out_Data 0xA0,0xA1,0xA2,0xA3,0xA0.
- Pointer skip/wrap (MODE 1): pointer=3, In_Valid=4'b0101 -> channel 0 granted, pointer becomes 1. Next grant goes to channel 2.
- Backpressure: Out_Ready=0 after a load of 0x5C from channel 2 -> Out_Valid=1, Out_Data=0x5C held for 5 cycles, In_Ready=0. Raise Out_Ready -> drain and new load in the same cycle.
- Fixed priority (MODE 0): In_Valid=4'b1010 -> channel 1 always wins while it stays valid; channel 3 is served only when In_Valid[1]=0.
- Forced (MODE 2): Selector=2 with In_Valid=4'b0100 -> transfer of channel 2. Selector=2 with In_Valid=4'b1011 -> no transfer, Out_Valid drops after drain. CHANNELS=3 with Selector=3 -> no In_Ready ever asserted.

Source files
------------

// File: rtl/rr_arbiter_mux.sv
// N-channel valid/ready multiplexer with fixed-priority, round-robin or forced
// channel selection feeding a single-entry registered output stage.
module rr_arbiter_mux #(
    parameter int WORD_LENGHT = 8,
    parameter int CHANNELS    = 4,
    parameter int MODE        = 1,
    parameter int SEL_W       = $clog2(CHANNELS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [CHANNELS-1:0]             In_Valid,
    input  logic [CHANNELS*WORD_LENGHT-1:0] In_Data,
    output logic [CHANNELS-1:0]             In_Ready,
    input  logic [SEL_W-1:0]                Selector,
    output logic                            Out_Valid,
    output logic [WORD_LENGHT-1:0]          Out_Data,
    output logic [SEL_W-1:0]                Out_Channel,
    input  logic                            Out_Ready
);

    localparam int MODE_FIXED  = 0;
    localparam int MODE_RR     = 1;
    localparam int MODE_FORCED = 2;

    localparam logic [SEL_W:0]   NCH     = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [WORD_LENGHT-1:0]   data_q, data_d;
    logic [SEL_W-1:0]         chan_q, chan_d;
    logic [SEL_W-1:0]         ptr_q, ptr_d;

    logic                     grant_found_s;
    logic [SEL_W-1:0]         grant_idx_s;
    logic [SEL_W:0]           rr_sum_s;
    logic                     load_en_s;
    logic                     xfer_s;

    // Grant selection; loops run high-to-low so the lowest candidate wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        rr_sum_s      = '0;
        case (MODE)
            MODE_FIXED: begin
                for (int i = CHANNELS - 1; i >= 0; i--) begin
                    grant_found_s = grant_found_s | In_Valid[i];
                    grant_idx_s   = In_Valid[i] ? SEL_W'(i) : grant_idx_s;
                end
            end
            MODE_RR: begin
                for (int j = CHANNELS - 1; j >= 0; j--) begin
                    rr_sum_s      = {1'b0, ptr_q} + (SEL_W+1)'(j);
                    rr_sum_s      = (rr_sum_s >= NCH) ? (rr_sum_s - NCH) : rr_sum_s;
                    grant_found_s = grant_found_s | In_Valid[rr_sum_s[SEL_W-1:0]];
                    grant_idx_s   = In_Valid[rr_sum_s[SEL_W-1:0]] ? rr_sum_s[SEL_W-1:0] : grant_idx_s;
                end
            end
            MODE_FORCED: begin
                // Out-of-range selector values never grant.
                grant_found_s = ({1'b0, Selector} < NCH) & In_Valid[Selector];
                grant_idx_s   = Selector;
            end
            default: begin
                grant_found_s = 1'b0;
                grant_idx_s   = '0;
            end
        endcase
    end

    // Handshake generation and next-state of the output stage and pointer.
    always_comb begin
        load_en_s = (state_q == EMPTY) | Out_Ready;
        In_Ready  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            In_Ready[i] = load_en_s & grant_found_s & (grant_idx_s == SEL_W'(i)) & ~reset;
        end
        xfer_s  = |(In_Ready & In_Valid);

        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        if (xfer_s) begin
            state_d = FULL;
            data_d  = In_Data[grant_idx_s*WORD_LENGHT +: WORD_LENGHT];
            chan_d  = grant_idx_s;
            ptr_d   = (MODE == MODE_RR) ?
                      ((grant_idx_s == LAST_CH) ? '0 : grant_idx_s + SEL_W'(1)) : '0;
        end else if (load_en_s) begin
            state_d = EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // State, output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign Out_Valid   = (state_q == FULL);
    assign Out_Data    = data_q;
    assign Out_Channel = chan_q;

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Bench for rr_arbiter_mux: directed scenarios on four configurations plus a
// randomized run checked against a cycle-level behavioural model.
module tb_rr_arbiter_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  iv   [4];
    logic [31:0] id   [4];
    logic [1:0]  sel  [4];
    logic        ordy [4];

    logic [3:0] ir0, ir1, ir2;
    logic [2:0] ir3;
    logic       ov0, ov1, ov2, ov3;
    logic [7:0] od0, od1, od2, od3;
    logic [1:0] oc0, oc1, oc2, oc3;

    int errors = 0;
    int checks = 0;

    int m_mode [4] = '{0, 1, 2, 2};
    int m_n    [4] = '{4, 4, 4, 3};

    rr_arbiter_mux #(.WORD_LENGHT(8), .CHANNELS(4), .MODE(0)) u0 (
        .clk(clk), .reset(rst), .In_Valid(iv[0]), .In_Data(id[0]), .In_Ready(ir0),
        .Selector(sel[0]), .Out_Valid(ov0), .Out_Data(od0), .Out_Channel(oc0), .Out_Ready(ordy[0]));
    rr_arbiter_mux #(.WORD_LENGHT(8), .CHANNELS(4), .MODE(1)) u1 (
        .clk(clk), .reset(rst), .In_Valid(iv[1]), .In_Data(id[1]), .In_Ready(ir1),
        .Selector(sel[1]), .Out_Valid(ov1), .Out_Data(od1), .Out_Channel(oc1), .Out_Ready(ordy[1]));
    rr_arbiter_mux #(.WORD_LENGHT(8), .CHANNELS(4), .MODE(2)) u2 (
        .clk(clk), .reset(rst), .In_Valid(iv[2]), .In_Data(id[2]), .In_Ready(ir2),
        .Selector(sel[2]), .Out_Valid(ov2), .Out_Data(od2), .Out_Channel(oc2), .Out_Ready(ordy[2]));
    rr_arbiter_mux #(.WORD_LENGHT(8), .CHANNELS(3), .MODE(2)) u3 (
        .clk(clk), .reset(rst), .In_Valid(iv[3][2:0]), .In_Data(id[3][23:0]), .In_Ready(ir3),
        .Selector(sel[3]), .Out_Valid(ov3), .Out_Data(od3), .Out_Channel(oc3), .Out_Ready(ordy[3]));

    function automatic logic [3:0] get_ir(int d);
        case (d)
            0: return ir0;
            1: return ir1;
            2: return ir2;
            3: return {1'b0, ir3};
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic get_ov(int d);
        case (d)
            0: return ov0;
            1: return ov1;
            2: return ov2;
            3: return ov3;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] get_od(int d);
        case (d)
            0: return od0;
            1: return od1;
            2: return od2;
            3: return od3;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int get_oc(int d);
        case (d)
            0: return int'(oc0);
            1: return int'(oc1);
            2: return int'(oc2);
            3: return int'(oc3);
            default: return 0;
        endcase
    endfunction

    // Reference choice of channel, straight from the selection rules; -1 = none.
    function automatic int model_grant(int mode, logic [3:0] v, int ptr, int s, int n);
        if (mode == 0) begin
            for (int k = 0; k < n; k++) if (v[k]) return k;
        end else if (mode == 1) begin
            for (int k = 0; k < n; k++) begin
                int c = (ptr + k) % n;
                if (v[c]) return c;
            end
        end else begin
            if (s < n && v[s]) return s;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            iv[d] = 4'b0000; id[d] = 32'h0; sel[d] = 2'd0; ordy[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            iv[d] = (d == 3) ? 4'b0111 : 4'b1111;
            id[d] = 32'hA3A2A1A0; sel[d] = 2'd0; ordy[d] = 1'b1;
        end
        repeat (2) begin
            @(posedge clk); #1;
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (get_ir(d) !== 4'b0000) begin errors++; $display("FAIL reset_in_ready dut%0d got=%b exp=0000", d, get_ir(d)); end
                checks++;
                if (get_ov(d) !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d got=%b exp=0", d, get_ov(d)); end
                checks++;
                if (get_od(d) !== 8'h00) begin errors++; $display("FAIL reset_out_data dut%0d got=%h exp=00", d, get_od(d)); end
                checks++;
                if (get_oc(d) != 0) begin errors++; $display("FAIL reset_out_channel dut%0d got=%0d exp=0", d, get_oc(d)); end
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ir1 !== 4'b0001) begin errors++; $display("FAIL reset_release_ready got=%b exp=0001", ir1); end
        @(posedge clk); #1;
        checks++;
        if (ov1 !== 1'b1 || oc1 !== 2'd0 || od1 !== 8'hA0)
            begin errors++; $display("FAIL reset_first_xfer got=v%b ch%0d d%h exp=v1 ch0 dA0", ov1, oc1, od1); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d;
        do_reset();
        iv[1] = 4'b1111; id[1] = 32'hA3A2A1A0; ordy[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            exp_d = 8'hA0 + 8'(k % 4);
            checks++;
            if (ov1 !== 1'b1 || int'(oc1) != k % 4 || od1 !== exp_d)
                begin errors++; $display("FAIL rr_sequence step%0d got=v%b ch%0d d%h exp=v1 ch%0d d%h", k, ov1, oc1, od1, k % 4, exp_d); end
        end
        iv[1] = 4'b0000;
    endtask

    task automatic test_pointer_wrap();
        do_reset();
        ordy[1] = 1'b1; iv[1] = 4'b0100; id[1] = 32'h00B20000;
        @(posedge clk); #1;
        checks++;
        if (oc1 !== 2'd2) begin errors++; $display("FAIL wrap_setup got=%0d exp=2", oc1); end
        iv[1] = 4'b0101; id[1] = 32'h00B200B0;
        #1;
        checks++;
        if (ir1 !== 4'b0001) begin errors++; $display("FAIL wrap_ready got=%b exp=0001", ir1); end
        @(posedge clk); #1;
        checks++;
        if (oc1 !== 2'd0 || od1 !== 8'hB0) begin errors++; $display("FAIL wrap_xfer got=ch%0d d%h exp=ch0 dB0", oc1, od1); end
        #1;
        checks++;
        if (ir1 !== 4'b0100) begin errors++; $display("FAIL wrap_next_ready got=%b exp=0100", ir1); end
        @(posedge clk); #1;
        checks++;
        if (oc1 !== 2'd2 || od1 !== 8'hB2) begin errors++; $display("FAIL wrap_next_xfer got=ch%0d d%h exp=ch2 dB2", oc1, od1); end
        iv[1] = 4'b0000;
    endtask

    task automatic test_backpressure();
        do_reset();
        ordy[1] = 1'b0; iv[1] = 4'b0100; id[1] = 32'h005C0000;
        @(posedge clk); #1;
        id[1] = 32'h00770000;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (ov1 !== 1'b1 || od1 !== 8'h5C || oc1 !== 2'd2 || ir1 !== 4'b0000)
                begin errors++; $display("FAIL bp_hold cyc%0d got=v%b d%h ch%0d rdy%b exp=v1 d5c ch2 rdy0000", k, ov1, od1, oc1, ir1); end
            @(posedge clk);
        end
        #1;
        ordy[1] = 1'b1;
        #1;
        checks++;
        if (ir1 !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got=%b exp=0100", ir1); end
        @(posedge clk); #1;
        checks++;
        if (ov1 !== 1'b1 || od1 !== 8'h77) begin errors++; $display("FAIL bp_reload got=v%b d%h exp=v1 d77", ov1, od1); end
        iv[1] = 4'b0000;
        @(posedge clk); #1;
        checks++;
        if (ov1 !== 1'b0 || od1 !== 8'h77) begin errors++; $display("FAIL bp_drain got=v%b d%h exp=v0 d77", ov1, od1); end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        ordy[0] = 1'b1; iv[0] = 4'b1010; id[0] = 32'h33001100;
        repeat (3) begin
            #1;
            checks++;
            if (ir0 !== 4'b0010) begin errors++; $display("FAIL fp_ready got=%b exp=0010", ir0); end
            @(posedge clk); #1;
            checks++;
            if (oc0 !== 2'd1 || od0 !== 8'h11) begin errors++; $display("FAIL fp_xfer got=ch%0d d%h exp=ch1 d11", oc0, od0); end
        end
        iv[0] = 4'b1000;
        #1;
        checks++;
        if (ir0 !== 4'b1000) begin errors++; $display("FAIL fp_low_ready got=%b exp=1000", ir0); end
        @(posedge clk); #1;
        checks++;
        if (oc0 !== 2'd3 || od0 !== 8'h33) begin errors++; $display("FAIL fp_low_xfer got=ch%0d d%h exp=ch3 d33", oc0, od0); end
        iv[0] = 4'b0000;
    endtask

    task automatic test_forced();
        do_reset();
        sel[2] = 2'd2; iv[2] = 4'b0100; id[2] = 32'h00220000; ordy[2] = 1'b1;
        #1;
        checks++;
        if (ir2 !== 4'b0100) begin errors++; $display("FAIL forced_ready got=%b exp=0100", ir2); end
        @(posedge clk); #1;
        checks++;
        if (ov2 !== 1'b1 || oc2 !== 2'd2 || od2 !== 8'h22) begin errors++; $display("FAIL forced_xfer got=v%b ch%0d d%h exp=v1 ch2 d22", ov2, oc2, od2); end
        iv[2] = 4'b1011;
        #1;
        checks++;
        if (ir2 !== 4'b0000) begin errors++; $display("FAIL forced_idle_ready got=%b exp=0000", ir2); end
        @(posedge clk); #1;
        checks++;
        if (ov2 !== 1'b0) begin errors++; $display("FAIL forced_drain got=%b exp=0", ov2); end
        iv[2] = 4'b0000;
        sel[3] = 2'd3; ordy[3] = 1'b1;
        repeat (8) begin
            iv[3] = {1'b0, 3'($urandom)}; id[3] = $urandom;
            #1;
            checks++;
            if (ir3 !== 3'b000) begin errors++; $display("FAIL forced_oob_ready got=%b exp=000", ir3); end
            @(posedge clk); #1;
            checks++;
            if (ov3 !== 1'b0) begin errors++; $display("FAIL forced_oob_valid got=%b exp=0", ov3); end
        end
        iv[3] = 4'b0000;
    endtask

    task automatic test_random();
        logic       m_full [4];
        logic [7:0] m_data [4];
        int         m_ch   [4];
        int         m_ptr  [4];
        logic [3:0] m_ir   [4];
        logic       m_load [4];
        int         g      [4];
        do_reset();
        for (int d = 0; d < 4; d++) begin
            m_full[d] = 1'b0; m_data[d] = 8'h00; m_ch[d] = 0; m_ptr[d] = 0; m_ir[d] = 4'b0000;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            // Producers keep an unserved word; otherwise they may offer a fresh one.
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < m_n[d]; c++) begin
                    if (!(iv[d][c] && !m_ir[d][c])) begin
                        iv[d][c] = (($urandom % 3) != 0);
                        id[d][c*8 +: 8] = 8'($urandom);
                    end
                end
                ordy[d] = (($urandom % 4) != 0);
                sel[d]  = 2'($urandom_range(0, 3));
            end
            rst = (($urandom % 64) == 0);
            #1;
            for (int d = 0; d < 4; d++) begin
                m_load[d] = !m_full[d] || ordy[d];
                g[d] = model_grant(m_mode[d], iv[d], m_ptr[d], int'(sel[d]), m_n[d]);
                m_ir[d] = (!rst && m_load[d] && g[d] >= 0) ? (4'b0001 << g[d]) : 4'b0000;
                checks++;
                if (get_ir(d) !== m_ir[d])
                    begin errors++; $display("FAIL rand_ready dut%0d cyc%0d got=%b exp=%b", d, cyc, get_ir(d), m_ir[d]); end
            end
            @(posedge clk); #1;
            for (int d = 0; d < 4; d++) begin
                if (rst) begin
                    m_full[d] = 1'b0; m_data[d] = 8'h00; m_ch[d] = 0; m_ptr[d] = 0;
                end else if (m_ir[d] != 4'b0000) begin
                    m_full[d] = 1'b1;
                    m_data[d] = id[d][g[d]*8 +: 8];
                    m_ch[d]   = g[d];
                    m_ptr[d]  = (m_mode[d] == 1) ? (g[d] + 1) % m_n[d] : 0;
                end else if (m_load[d]) begin
                    m_full[d] = 1'b0;
                end
                checks++;
                if (get_ov(d) !== m_full[d] || get_od(d) !== m_data[d] || get_oc(d) != m_ch[d])
                    begin errors++; $display("FAIL rand_output dut%0d cyc%0d got=v%b d%h ch%0d exp=v%b d%h ch%0d",
                        d, cyc, get_ov(d), get_od(d), get_oc(d), m_full[d], m_data[d], m_ch[d]); end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_pointer_wrap();
        test_backpressure();
        test_fixed_priority();
        test_forced();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
